// File: rtl/vmul_quad_pipe.sv
// vmul_quad_pipe: two-stage unsigned multiplier built from four half-width partial
// products. It produces either one full-width product or two independent lane products.
module vmul_quad_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               out_mode,
  output logic               busy
);
  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned MW = WIDTH + 1;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_mode_q;
  logic [WIDTH-1:0] ll_q, lh_q, hl_q, hh_q;
  logic [WIDTH-1:0] ll_d, lh_d, hl_d, hh_d;
  logic             out_valid_q, out_valid_d;
  logic             out_mode_q;
  logic [W2-1:0]    result_q, result_d;

  logic s2_adv, s1_adv, s1_load, s2_load;

  // Handshake and advance control
  always_comb begin
    s2_adv      = !out_valid_q || out_ready;
    s1_adv      = !s1_valid_q || s2_adv;
    s1_load     = in_valid && s1_adv;
    s2_load     = s1_valid_q && s2_adv;
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    if (s1_adv) s1_valid_d = in_valid;
    if (s2_adv) out_valid_d = s1_valid_q;
  end

  // Quadrant partial products
  always_comb begin
    ll_d = WIDTH'(a[H-1:0])     * WIDTH'(b[H-1:0]);
    lh_d = WIDTH'(a[H-1:0])     * WIDTH'(b[WIDTH-1:H]);
    hl_d = WIDTH'(a[WIDTH-1:H]) * WIDTH'(b[H-1:0]);
    hh_d = WIDTH'(a[WIDTH-1:H]) * WIDTH'(b[WIDTH-1:H]);
  end

  // Merge: the cross-term sum keeps its carry; lane mode concatenates the diagonal products
  logic [MW-1:0] mid_c;
  always_comb begin
    mid_c    = MW'(lh_q) + MW'(hl_q);
    result_d = (W2'(hh_q) << WIDTH) + (W2'(mid_c) << H) + W2'(ll_q);
    if (s1_mode_q) result_d = {hh_q, ll_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_mode_q  <= 1'b0;
      result_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      if (s2_load) begin
        result_q   <= result_d;
        out_mode_q <= s1_mode_q;
      end
    end
  end

  // Stage-1 data has no reset; it is only ever observed behind s1_valid_q
  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_mode_q <= mode;
      ll_q      <= ll_d;
      lh_q      <= lh_d;
      hl_q      <= hl_d;
      hh_q      <= hh_d;
    end
  end

  assign in_ready  = s1_adv;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign out_mode  = out_mode_q;
  assign busy      = s1_valid_q || out_valid_q;

endmodule
